instr_step_controller: RTL and testbench
========================================

Name: instr_step_controller

Overview:
- Single-step instruction sequencer for the TP1 CPU on the DE2 board: one debounced KEY[3] press issues exactly one instruction taken from SW[15:0].
- Captures the instruction fields and drives the register-file read, ALU start and register-file write strobes through a fixed multi-cycle sequence.
- Sits between the board switches/keys and the register file + ALU datapath.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable cycles needed to accept a key level change (1 ms at 50 MHz)
ALU_LATENCY, 2, cycles spent in EXEC, range 1..15

Ports:
clock  input  1  system clock, 50 MHz (CLOCK_50)
reset_n  input  1  asynchronous, active-low reset
key_n  input  1  raw KEY[3], active-low, asynchronous to clock
sw  input  16  raw SW[15:0]
codop  output  4  latched opcode
addA  output  4  latched source A address
addB_LMM  output  4  latched source B address, or immediate for LMM
addC  output  4  latched destination address
rf_rd_en  output  1  register-file read strobe
alu_start  output  1  ALU start strobe
rf_wr_en  output  1  register-file write strobe
wr_sel_imm  output  1  write-data select: 1 = immediate, 0 = ALU result
busy  output  1  instruction in flight
illegal_op  output  1  last issued opcode undefined (sticky)
instr_count  output  8  instructions issued, wraps at 255 -> 0

Behaviour:
- Reset, asynchronous while reset_n=0:
  - All outputs 0; FSM in IDLE; debounce counter 0.
  - Debounced key state = released.
  - Reset mid-instruction abandons it, with no write strobe.
- key_n is synchronised through 2 flops. The debounce counter increments while the synchronised level differs from the debounced state and clears otherwise. On reaching DEBOUNCE_CYCLES-1 the debounced state toggles and the counter clears.
- A press event is a 1-cycle pulse on the debounced released->pressed transition. The release transition generates nothing. A held key issues once only.
- A press event while busy=1 is dropped, not queued.
- Field map, captured from raw sw in FETCH:
  - codop[0..3] = sw[15..12]
  - addA[0..3] = sw[11..8]
  - addB_LMM[0..3] = sw[7..4]
  - addC[0..3] = sw[3..0]
  - Bit order is reversed per field (switch nearest the MSB drives bit 0).
- The four field outputs hold their value until the next FETCH.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (ALU ops)
  - 15 LMM
  - 7..14 illegal
- FSM states: IDLE, FETCH, DECODE, READ, EXEC, WRITE.
  - IDLE: press event -> FETCH.
  - FETCH: latch fields; instr_count += 1 (mod 256); illegal_op cleared -> DECODE.
  - DECODE:
    - ALU op -> READ.
    - LMM -> WRITE.
    - NOP -> IDLE.
    - Illegal -> IDLE with illegal_op=1.
  - READ: rf_rd_en=1 for 1 cycle -> EXEC.
  - EXEC:
    - alu_start=1 in the first EXEC cycle only.
    - Stays ALU_LATENCY cycles -> WRITE.
  - WRITE: rf_wr_en=1 for 1 cycle; wr_sel_imm=1 iff codop=15, else 0 -> IDLE.
- busy=1 in FETCH through WRITE, 0 in IDLE. All strobes are registered Moore outputs, 0 outside their stated state.
- Latency from press event:
  - ALU op: rf_wr_en asserted at event + 4 + ALU_LATENCY cycles.
  - LMM: rf_wr_en asserted at event + 3 cycles.
- sw changes after FETCH have no effect on the instruction in flight.
- Press event in the same cycle WRITE->IDLE occurs: dropped, because busy=1 in that cycle.

Test Plan (DEBOUNCE_CYCLES=4, ALU_LATENCY=2):
- Reset: reset_n=0 mid-EXEC -> all outputs 0 immediately (async); after release FSM in IDLE, no rf_wr_en.
- ADD: sw=16'h8C4A, key_n low 10 cycles -> codop=1, addA=3, addB_LMM=2, addC=5; rf_rd_en, alu_start, rf_wr_en each 1 cycle; rf_wr_en at event+6; wr_sel_imm=0; instr_count=1.
- LMM: sw=16'hF0E8 -> codop=15, addB_LMM=7, addC=1; no rf_rd_en or alu_start; rf_wr_en at event+3 with wr_sel_imm=1.
- Illegal and NOP: codop=14 -> illegal_op=1, no strobes; next press with codop=0 -> illegal_op=0, no strobes, instr_count incremented.
- Debounce: key_n glitches low 2 cycles -> no issue; key held low 1000 cycles -> exactly one issue; second press during busy -> ignored.
- Wrap: 256 NOP presses -> instr_count returns to 0.

Source files
------------

// File: rtl/instr_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : instr_step_controller                                      |
// | Description : Single-step sequencer; one debounced key press issues one  |
// |               instruction from the switches through RF read/ALU/write.   |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module instr_step_controller #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int          ALU_LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        key_n,
    input  logic [15:0] sw,
    output logic [3:0]  codop,
    output logic [3:0]  addA,
    output logic [3:0]  addB_LMM,
    output logic [3:0]  addC,
    output logic        rf_rd_en,
    output logic        alu_start,
    output logic        rf_wr_en,
    output logic        wr_sel_imm,
    output logic        busy,
    output logic        illegal_op,
    output logic [7:0]  instr_count
);

    localparam logic [15:0] c_deb_last  = DEBOUNCE_CYCLES - 16'd1;
    localparam logic [3:0]  c_exec_last = 4'(ALU_LATENCY - 1);
    localparam logic [3:0]  c_op_nop    = 4'd0;
    localparam logic [3:0]  c_op_slt    = 4'd6;
    localparam logic [3:0]  c_op_lmm    = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_WRITE  = 3'd5
    } state_t;

    logic [1:0]  r_sync;
    logic        r_db;
    logic [15:0] r_db_cnt;
    logic        r_press;
    state_t      r_state;
    logic [3:0]  r_exec_cnt;

    // Switch nearest the field MSB drives bit 0 of the captured field.
    function automatic logic [3:0] rev4(input logic [3:0] v);
        rev4 = {v[0], v[1], v[2], v[3]};
    endfunction

    // Key levels are active-low: r_db = 1 means released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= 2'b11;
            r_db     <= 1'b1;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_deb_last) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
                r_press  <= r_db;
            end else begin
                r_db_cnt <= r_db_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_exec_cnt  <= '0;
            codop       <= '0;
            addA        <= '0;
            addB_LMM    <= '0;
            addC        <= '0;
            rf_rd_en    <= 1'b0;
            alu_start   <= 1'b0;
            rf_wr_en    <= 1'b0;
            wr_sel_imm  <= 1'b0;
            busy        <= 1'b0;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            rf_rd_en   <= 1'b0;
            alu_start  <= 1'b0;
            rf_wr_en   <= 1'b0;
            wr_sel_imm <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_press) begin
                        r_state <= S_FETCH;
                        busy    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    codop       <= rev4(sw[15:12]);
                    addA        <= rev4(sw[11:8]);
                    addB_LMM    <= rev4(sw[7:4]);
                    addC        <= rev4(sw[3:0]);
                    instr_count <= instr_count + 8'd1;
                    illegal_op  <= 1'b0;
                    r_state     <= S_DECODE;
                end
                S_DECODE: begin
                    if (codop == c_op_lmm) begin
                        r_state    <= S_WRITE;
                        rf_wr_en   <= 1'b1;
                        wr_sel_imm <= 1'b1;
                    end else if (codop == c_op_nop) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (codop <= c_op_slt) begin
                        r_state  <= S_READ;
                        rf_rd_en <= 1'b1;
                    end else begin
                        r_state    <= S_IDLE;
                        busy       <= 1'b0;
                        illegal_op <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state    <= S_EXEC;
                    alu_start  <= 1'b1;
                    r_exec_cnt <= '0;
                end
                S_EXEC: begin
                    if (r_exec_cnt == c_exec_last) begin
                        r_state  <= S_WRITE;
                        rf_wr_en <= 1'b1;
                    end else begin
                        r_exec_cnt <= r_exec_cnt + 4'd1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_step_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_instr_step_controller                                   |
// | Description : Self-checking bench for instr_step_controller (fast and    |
// |               slow ALU latency instances against a schedule model).      |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_instr_step_controller;

    localparam logic [15:0] DEB   = 16'd4;
    localparam int          DEBI  = 4;
    localparam int          LAT_F = 2;
    localparam int          LAT_S = 12;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_n   = 1'b1;
    logic [15:0] sw      = 16'h0000;

    always #10 clock = ~clock;

    logic [3:0] f_op, f_a, f_b, f_c, s_op, s_a, s_b, s_c;
    logic       f_rd, f_st, f_wr, f_sel, f_busy, f_ill;
    logic       s_rd, s_st, s_wr, s_sel, s_busy, s_ill;
    logic [7:0] f_cnt, s_cnt;
    logic [29:0] f_vec, s_vec;

    instr_step_controller #(.DEBOUNCE_CYCLES(DEB), .ALU_LATENCY(LAT_F)) u_fast (
        .clock(clock), .reset_n(reset_n), .key_n(key_n), .sw(sw),
        .codop(f_op), .addA(f_a), .addB_LMM(f_b), .addC(f_c),
        .rf_rd_en(f_rd), .alu_start(f_st), .rf_wr_en(f_wr), .wr_sel_imm(f_sel),
        .busy(f_busy), .illegal_op(f_ill), .instr_count(f_cnt)
    );

    instr_step_controller #(.DEBOUNCE_CYCLES(DEB), .ALU_LATENCY(LAT_S)) u_slow (
        .clock(clock), .reset_n(reset_n), .key_n(key_n), .sw(sw),
        .codop(s_op), .addA(s_a), .addB_LMM(s_b), .addC(s_c),
        .rf_rd_en(s_rd), .alu_start(s_st), .rf_wr_en(s_wr), .wr_sel_imm(s_sel),
        .busy(s_busy), .illegal_op(s_ill), .instr_count(s_cnt)
    );

    assign f_vec = {f_op, f_a, f_b, f_c, f_rd, f_st, f_wr, f_sel, f_busy, f_ill, f_cnt};
    assign s_vec = {s_op, s_a, s_b, s_c, s_rd, s_st, s_wr, s_sel, s_busy, s_ill, s_cnt};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] fld(input logic [15:0] v, input int hi);
        logic [3:0] r;
        for (int b = 0; b < 4; b++) r[b] = v[hi - b];
        return r;
    endfunction

    // 0 = NOP, 1 = ALU op, 2 = LMM, 3 = illegal
    function automatic int kind_of(input logic [3:0] op);
        if (op == 4'd0)  return 0;
        if (op <= 4'd6)  return 1;
        if (op == 4'd15) return 2;
        return 3;
    endfunction

    // Edges from acceptance until the controller is idle again.
    function automatic int len_of(input int k, input int lat);
        if (k == 1) return 4 + lat;
        if (k == 2) return 3;
        return 2;
    endfunction

    bit         kh [0:DEBI+1];
    bit         m_db, m_press, m_dif;
    bit         m_act [0:1];
    int         m_ph  [0:1];
    int         m_lat, m_k;
    logic [3:0] m_op [0:1], m_a [0:1], m_b [0:1], m_c [0:1];
    logic       m_rd [0:1], m_st [0:1], m_wr [0:1], m_sel [0:1], m_busy [0:1], m_ill [0:1];
    logic [7:0] m_cnt [0:1];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j <= DEBI + 1; j++) kh[j] = 1'b1;
            m_db    = 1'b1;
            m_press = 1'b0;
            for (int u = 0; u < 2; u++) begin
                m_act[u] = 1'b0; m_ph[u] = 0;
                m_op[u] = '0; m_a[u] = '0; m_b[u] = '0; m_c[u] = '0;
                m_rd[u] = 1'b0; m_st[u] = 1'b0; m_wr[u] = 1'b0; m_sel[u] = 1'b0;
                m_busy[u] = 1'b0; m_ill[u] = 1'b0; m_cnt[u] = '0;
            end
        end else begin
            for (int j = DEBI + 1; j > 0; j--) kh[j] = kh[j-1];
            kh[0] = key_n;
            for (int u = 0; u < 2; u++) begin
                m_lat = (u == 0) ? LAT_F : LAT_S;
                m_rd[u] = 1'b0; m_st[u] = 1'b0; m_wr[u] = 1'b0; m_sel[u] = 1'b0;
                if (!m_act[u]) begin
                    if (m_press) begin
                        m_act[u]  = 1'b1;
                        m_ph[u]   = 0;
                        m_busy[u] = 1'b1;
                    end
                end else begin
                    m_ph[u]++;
                    if (m_ph[u] == 1) begin
                        m_op[u]  = fld(sw, 15);
                        m_a[u]   = fld(sw, 11);
                        m_b[u]   = fld(sw, 7);
                        m_c[u]   = fld(sw, 3);
                        m_cnt[u] = m_cnt[u] + 8'd1;
                        m_ill[u] = 1'b0;
                    end else begin
                        m_k = kind_of(m_op[u]);
                        if (m_ph[u] == len_of(m_k, m_lat)) begin
                            m_act[u]  = 1'b0;
                            m_busy[u] = 1'b0;
                            if (m_k == 3) m_ill[u] = 1'b1;
                        end else if (m_k == 1) begin
                            m_rd[u] = (m_ph[u] == 2);
                            m_st[u] = (m_ph[u] == 3);
                            m_wr[u] = (m_ph[u] == 3 + m_lat);
                        end else if (m_k == 2) begin
                            m_wr[u]  = 1'b1;
                            m_sel[u] = 1'b1;
                        end
                    end
                end
            end
            // Debounced level flips once the last DEBI synchronised samples all disagree.
            m_dif = 1'b1;
            for (int j = 2; j <= DEBI + 1; j++) if (kh[j] == m_db) m_dif = 1'b0;
            m_press = m_dif && m_db;
            if (m_dif) m_db = ~m_db;
        end
    end

    bit chk_on = 1'b0;
    always @(negedge clock) begin
        if (chk_on) begin
            chk("model_fast", {2'b00, f_vec}, {2'b00, m_op[0], m_a[0], m_b[0], m_c[0], m_rd[0], m_st[0],
                m_wr[0], m_sel[0], m_busy[0], m_ill[0], m_cnt[0]});
            chk("model_slow", {2'b00, s_vec}, {2'b00, m_op[1], m_a[1], m_b[1], m_c[1], m_rd[1], m_st[1],
                m_wr[1], m_sel[1], m_busy[1], m_ill[1], m_cnt[1]});
        end
    end

    // ---------------- pulse monitor (fast instance) ----------------
    int   rd_n = 0, st_n = 0, wr_n = 0, wr_cyc = 0;
    logic sel_at_wr = 1'b0;
    int   busy_n = 0;
    always @(negedge clock) begin
        if (f_rd) rd_n++;
        if (f_st) st_n++;
        if (f_wr) begin
            wr_n++;
            wr_cyc    = cyc;
            sel_at_wr = f_sel;
        end
        if (f_busy) busy_n++;
    end

    task automatic issue(input logic [15:0] v, input int low_cycles, output int k0);
        @(negedge clock);
        sw    = v;
        key_n = 1'b0;
        k0    = cyc + 1;
        repeat (low_cycles - 1) @(negedge clock);
        sw = ~v;
        @(negedge clock);
        key_n = 1'b1;
        repeat (40) @(negedge clock);
    endtask

    typedef struct {
        logic [15:0] sw;
        logic [3:0]  op, a, b, c;
        int          kind;
    } vec_t;

    vec_t       tbl [0:6];
    logic [7:0] exp_f = 8'd0, exp_s = 8'd0;
    int         k0, b_rd, b_st, b_wr, b_busy;

    initial begin
        tbl[0] = '{16'h8C4A, 4'd1,  4'd3,  4'd2,  4'd5,  1};
        tbl[1] = '{16'hF0E8, 4'd15, 4'd0,  4'd7,  4'd1,  2};
        tbl[2] = '{16'h7123, 4'd14, 4'd8,  4'd4,  4'd12, 3};
        tbl[3] = '{16'h0ABC, 4'd0,  4'd5,  4'd13, 4'd3,  0};
        tbl[4] = '{16'h6F01, 4'd6,  4'd15, 4'd0,  4'd8,  1};
        tbl[5] = '{16'hA5D7, 4'd5,  4'd10, 4'd11, 4'd14, 1};
        tbl[6] = '{16'hE000, 4'd7,  4'd0,  4'd0,  4'd0,  3};

        repeat (3) @(negedge clock);
        chk("reset_fast", {2'b00, f_vec}, 32'd0);
        chk("reset_slow", {2'b00, s_vec}, 32'd0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        repeat (5) @(negedge clock);

        // Two-cycle glitch must not issue.
        b_busy = busy_n;
        key_n = 1'b0;
        repeat (2) @(negedge clock);
        key_n = 1'b1;
        repeat (20) @(negedge clock);
        chk("glitch_count", f_cnt, exp_f);
        chk("glitch_busy", busy_n - b_busy, 0);

        for (int i = 0; i < 7; i++) begin
            b_rd = rd_n; b_st = st_n; b_wr = wr_n;
            issue(tbl[i].sw, 10, k0);
            exp_f = exp_f + 8'd1;
            exp_s = exp_s + 8'd1;
            chk("fields", {f_op, f_a, f_b, f_c}, {tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].c});
            chk("instr_count", f_cnt, exp_f);
            chk("illegal_op", f_ill, tbl[i].kind == 3);
            chk("rd_pulses", rd_n - b_rd, tbl[i].kind == 1);
            chk("start_pulses", st_n - b_st, tbl[i].kind == 1);
            chk("wr_pulses", wr_n - b_wr, (tbl[i].kind == 1) || (tbl[i].kind == 2));
            if (tbl[i].kind == 1) begin
                chk("wr_latency_alu", wr_cyc - k0, DEBI + 5 + LAT_F);
                chk("wr_sel_alu", sel_at_wr, 1'b0);
            end
            if (tbl[i].kind == 2) begin
                chk("wr_latency_lmm", wr_cyc - k0, DEBI + 4);
                chk("wr_sel_lmm", sel_at_wr, 1'b1);
            end
            chk("idle_after", f_busy, 1'b0);
        end

        // Held key issues exactly once.
        issue(16'h8C4A, 1000, k0);
        exp_f = exp_f + 8'd1;
        exp_s = exp_s + 8'd1;
        chk("hold_count_fast", f_cnt, exp_f);
        chk("hold_count_slow", s_cnt, exp_s);

        // Second press lands while the slow instance is still busy.
        @(negedge clock);
        sw = 16'h8C4A;
        key_n = 1'b0;
        repeat (6) @(negedge clock);
        key_n = 1'b1;
        repeat (6) @(negedge clock);
        key_n = 1'b0;
        repeat (10) @(negedge clock);
        key_n = 1'b1;
        repeat (40) @(negedge clock);
        exp_f = exp_f + 8'd2;
        exp_s = exp_s + 8'd1;
        chk("busy_drop_fast", f_cnt, exp_f);
        chk("busy_drop_slow", s_cnt, exp_s);

        // Asynchronous reset in the middle of EXEC.
        @(negedge clock);
        sw = 16'h8C4A;
        key_n = 1'b0;
        for (int t = 0; t < 50 && !f_st; t++) @(negedge clock);
        chk("exec_reached", f_st, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_reset_fast", {2'b00, f_vec}, 32'd0);
        chk("async_reset_slow", {2'b00, s_vec}, 32'd0);
        @(negedge clock);
        key_n = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        b_wr = wr_n;
        repeat (20) @(negedge clock);
        exp_f = 8'd0;
        exp_s = 8'd0;
        chk("abandon_no_write", wr_n - b_wr, 0);
        chk("abandon_idle", f_busy, 1'b0);

        // 256 NOPs wrap the instruction counter.
        sw = 16'h0000;
        for (int p = 0; p < 256; p++) begin
            @(negedge clock);
            key_n = 1'b0;
            repeat (6) @(negedge clock);
            key_n = 1'b1;
            repeat (5) @(negedge clock);
            if (p == 254) begin
                repeat (5) @(negedge clock);
                chk("count_255", f_cnt, 8'd255);
            end
        end
        repeat (20) @(negedge clock);
        exp_f = 8'(exp_f + 9'd256);
        exp_s = 8'(exp_s + 9'd256);
        chk("wrap_fast", f_cnt, exp_f);
        chk("wrap_slow", s_cnt, exp_s);

        // Randomised key bouncing and switch churn against the model.
        for (int r = 0; r < 3000; r++) begin
            @(negedge clock);
            if ($urandom_range(5) == 0) key_n = ~key_n;
            sw = 16'($urandom);
        end
        @(negedge clock);
        key_n = 1'b1;
        repeat (40) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
